// File: rtl/wdt_feeder.sv
// wdt_feeder: periodic watchdog kick, issued only after every task checks in; registered outputs, no backpressure.
// Optional WDT_FEED_EARLY_KICK_EN: kick as soon as all tasks have checked in, without waiting for window end.
module wdt_feeder #(
  parameter int NUM_TASKS = 4,
  parameter int PULSE_LEN = 2,
  parameter int CNT_W     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic [CNT_W-1:0]     i_kick_period,
  input  logic [CNT_W-1:0]     i_holdoff,
  input  logic [NUM_TASKS-1:0] i_task_alive,
  input  logic                 i_fail_safe,
  input  logic                 i_hardware_rst,
  output logic                 o_clrwdt,
  output logic [2:0]           o_state,
  output logic [NUM_TASKS-1:0] o_missed_tasks,
  output logic [7:0]           o_fail_count,
  output logic [7:0]           o_rst_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLDOFF = 3'd1,
    COLLECT = 3'd2,
    KICK    = 3'd3,
    SUSPEND = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [NUM_TASKS-1:0] mask_q, mask_d;
  logic [NUM_TASKS-1:0] missed_d;
  logic [NUM_TASKS-1:0] eval;
  logic [CNT_W-1:0]     hold_ld, per_ld;
  logic                 all_in;
  logic                 fs_q, hr_q;

  // A zero length is treated as a one-cycle phase.
  assign hold_ld = (i_holdoff == '0)     ? '0 : i_holdoff - CNT_W'(1);
  assign per_ld  = (i_kick_period == '0) ? '0 : i_kick_period - CNT_W'(1);
  assign eval    = mask_q | i_task_alive;
  assign all_in  = &eval;
  assign o_state = state_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    mask_d   = mask_q;
    missed_d = o_missed_tasks;
    if (!i_enable) begin
      state_d = IDLE;
    end else if (i_hardware_rst && (state_q inside {HOLDOFF, COLLECT, KICK})) begin
      state_d = SUSPEND;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = HOLDOFF;
          timer_d = hold_ld;
        end
        HOLDOFF: begin
          if (timer_q == '0) begin
            state_d = COLLECT;
            timer_d = per_ld;
            mask_d  = '0;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        COLLECT: begin
          if (timer_q == '0) begin
            mask_d = '0;
            if (all_in) begin
              state_d  = KICK;
              timer_d  = PULSE_LD;
              missed_d = '0;
            end else begin
              timer_d  = per_ld;
              missed_d = ~eval;
            end
          end
`ifdef WDT_FEED_EARLY_KICK_EN
          else if (all_in) begin
            state_d  = KICK;
            timer_d  = PULSE_LD;
            mask_d   = '0;
            missed_d = '0;
          end
`endif
          else begin
            mask_d  = eval;
            timer_d = timer_q - CNT_W'(1);
          end
        end
        KICK: begin
          if (timer_q == '0) begin
            state_d = COLLECT;
            timer_d = per_ld;
            mask_d  = '0;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        SUSPEND: begin
          if (!i_hardware_rst) begin
            state_d = HOLDOFF;
            timer_d = hold_ld;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      mask_q         <= '0;
      o_missed_tasks <= '0;
      o_clrwdt       <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      mask_q         <= mask_d;
      o_missed_tasks <= missed_d;
      o_clrwdt       <= (state_d == KICK);
    end
  end

  // Event counters run in every state, including IDLE and SUSPEND.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fs_q         <= 1'b0;
      hr_q         <= 1'b0;
      o_fail_count <= 8'd0;
      o_rst_count  <= 8'd0;
    end else begin
      fs_q <= i_fail_safe;
      hr_q <= i_hardware_rst;
      if (i_fail_safe && !fs_q && (o_fail_count != 8'hFF))
        o_fail_count <= o_fail_count + 8'd1;
      if (i_hardware_rst && !hr_q && (o_rst_count != 8'hFF))
        o_rst_count <= o_rst_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_wdt_feeder.sv
// Bench for wdt_feeder: directed vector table, hand-written corner sequences, then random stimulus vs a phase model.
module tb_wdt_feeder;
  localparam int NT = 4;
  localparam int PL = 2;
  localparam int CW = 32;
`ifdef WDT_FEED_EARLY_KICK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_enable;
  logic [CW-1:0] i_kick_period;
  logic [CW-1:0] i_holdoff;
  logic [NT-1:0] i_task_alive;
  logic          i_fail_safe;
  logic          i_hardware_rst;
  logic          o_clrwdt;
  logic [2:0]    o_state;
  logic [NT-1:0] o_missed_tasks;
  logic [7:0]    o_fail_count;
  logic [7:0]    o_rst_count;

  wdt_feeder #(.NUM_TASKS(NT), .PULSE_LEN(PL), .CNT_W(CW)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_kick_period  (i_kick_period),
    .i_holdoff      (i_holdoff),
    .i_task_alive   (i_task_alive),
    .i_fail_safe    (i_fail_safe),
    .i_hardware_rst (i_hardware_rst),
    .o_clrwdt       (o_clrwdt),
    .o_state        (o_state),
    .o_missed_tasks (o_missed_tasks),
    .o_fail_count   (o_fail_count),
    .o_rst_count    (o_rst_count)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic          en;
    logic [NT-1:0] alive;
    logic [2:0]    st;
    logic          clr;
    logic [NT-1:0] missed;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic en, input logic [NT-1:0] alive,
                              input logic [2:0] st, input logic clr, input logic [NT-1:0] missed);
    vec_t v;
    v = '{en, alive, st, clr, missed};
    tbl.push_back(v);
  endfunction

  // Reference model: phases with remaining-cycle counts, derived from the behavioural rules.
  int m_st, m_left, m_seen, m_missed, m_fail, m_rst, m_clr;
  int m_fs_prev, m_hr_prev;

  function automatic int len(input logic [CW-1:0] x);
    return (x == '0) ? 1 : int'(x);
  endfunction

  task automatic model_reset();
    m_st = 0; m_left = 0; m_seen = 0; m_missed = 0;
    m_fail = 0; m_rst = 0; m_clr = 0; m_fs_prev = 0; m_hr_prev = 0;
  endtask

  task automatic model_tick();
    int all_t;
    all_t = (1 << NT) - 1;
    if (i_fail_safe && m_fs_prev == 0 && m_fail < 255) m_fail++;
    if (i_hardware_rst && m_hr_prev == 0 && m_rst < 255) m_rst++;
    m_fs_prev = int'(i_fail_safe);
    m_hr_prev = int'(i_hardware_rst);
    if (!i_enable) begin
      m_st = 0;
    end else if (i_hardware_rst && m_st >= 1 && m_st <= 3) begin
      m_st = 4;
    end else begin
      case (m_st)
        0: begin m_st = 1; m_left = len(i_holdoff); end
        1: begin
          m_left--;
          if (m_left == 0) begin m_st = 2; m_left = len(i_kick_period); m_seen = 0; end
        end
        2: begin
          m_seen = m_seen | int'(i_task_alive);
          m_left--;
          if (m_seen == all_t && (m_left == 0 || EARLY)) begin
            m_st = 3; m_left = PL; m_missed = 0;
          end else if (m_left == 0) begin
            m_missed = ~m_seen & all_t; m_left = len(i_kick_period); m_seen = 0;
          end
        end
        3: begin
          m_left--;
          if (m_left == 0) begin m_st = 2; m_left = len(i_kick_period); m_seen = 0; end
        end
        default: if (!i_hardware_rst) begin m_st = 1; m_left = len(i_holdoff); end
      endcase
    end
    m_clr = (m_st == 3) ? 1 : 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hw_left;
    i_rst_n = 1'b0; i_enable = 1'b0; i_kick_period = 10; i_holdoff = 3;
    i_task_alive = '0; i_fail_safe = 1'b0; i_hardware_rst = 1'b0;

    // Vector table: holdoff 3, period 10; row k is applied during cycle k, checked in cycle k+1.
    repeat (3) add(1, 4'b0000, 3'd1, 0, 4'b0000);
    add(1, 4'b0000, 3'd2, 0, 4'b0000);
    add(1, 4'b0001, 3'd2, 0, 4'b0000);
    add(1, 4'b0010, 3'd2, 0, 4'b0000);
    add(1, 4'b0100, 3'd2, 0, 4'b0000);
    repeat (6) add(1, 4'b0000, 3'd2, 0, 4'b0000);
    add(1, 4'b1000, 3'd3, 1, 4'b0000);
    add(1, 4'b0000, 3'd3, 1, 4'b0000);
    add(1, 4'b0000, 3'd2, 0, 4'b0000);
    add(1, 4'b1011, 3'd2, 0, 4'b0000);
    repeat (8) add(1, 4'b0000, 3'd2, 0, 4'b0000);
    add(1, 4'b0000, 3'd2, 0, 4'b0100);
    add(1, 4'b0011, 3'd2, 0, 4'b0100);
    repeat (8) add(1, 4'b0000, 3'd2, 0, 4'b0100);
    add(1, 4'b1100, 3'd3, 1, 4'b0000);
    add(1, 4'b0000, 3'd3, 1, 4'b0000);
    add(1, 4'b0000, 3'd2, 0, 4'b0000);

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_clr", 32'(o_clrwdt), 32'd0);
    chk("rst_missed", 32'(o_missed_tasks), 32'd0);
    chk("rst_fail", 32'(o_fail_count), 32'd0);
    chk("rst_rstcnt", 32'(o_rst_count), 32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      i_enable = tbl[i].en;
      i_task_alive = tbl[i].alive;
      tick();
      chk($sformatf("tbl%0d_state", i), 32'(o_state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_clr", i), 32'(o_clrwdt), 32'(tbl[i].clr));
      chk($sformatf("tbl%0d_missed", i), 32'(o_missed_tasks), 32'(tbl[i].missed));
    end

    // Hardware reset for 5 cycles starting in the first KICK cycle.
    i_task_alive = '0;
    repeat (9) tick();
    i_task_alive = 4'b1111;
    tick();
    chk("hw_pre_state", 32'(o_state), 32'd3);
    chk("hw_pre_clr", 32'(o_clrwdt), 32'd1);
    i_task_alive = '0;
    i_hardware_rst = 1'b1;
    tick();
    chk("hw_state", 32'(o_state), 32'd4);
    chk("hw_clr", 32'(o_clrwdt), 32'd0);
    chk("hw_rstcnt", 32'(o_rst_count), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hw_hold_state", 32'(o_state), 32'd4);
    end
    i_hardware_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hw_holdoff_state", 32'(o_state), 32'd1);
    end
    tick();
    chk("hw_collect_state", 32'(o_state), 32'd2);
    chk("hw_rstcnt_once", 32'(o_rst_count), 32'd1);

    // Fail-safe edges: a held level counts once, and the count saturates.
    i_fail_safe = 1'b1;
    repeat (3) tick();
    i_fail_safe = 1'b0;
    tick();
    chk("fs_first", 32'(o_fail_count), 32'd1);
    for (int k = 1; k < 300; k++) begin
      i_fail_safe = 1'b1;
      tick();
      i_fail_safe = 1'b0;
      tick();
      if (k == 254) chk("fs_255", 32'(o_fail_count), 32'd255);
    end
    chk("fs_sat", 32'(o_fail_count), 32'd255);

    // Disable retains diagnostics.
    i_enable = 1'b0;
    tick();
    chk("dis_state", 32'(o_state), 32'd0);
    chk("dis_clr", 32'(o_clrwdt), 32'd0);
    chk("dis_missed", 32'(o_missed_tasks), 32'hF);
    chk("dis_fail", 32'(o_fail_count), 32'd255);
    chk("dis_rstcnt", 32'(o_rst_count), 32'd1);

    // Zero period and holdoff with tasks always alive: 0,1,1 kick pattern.
    i_kick_period = 0; i_holdoff = 0; i_task_alive = 4'b1111; i_enable = 1'b1;
    tick();
    chk("p0_holdoff", 32'(o_state), 32'd1);
    tick();
    chk("p0_collect", 32'(o_state), 32'd2);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("p0_clr%0d", k), 32'(o_clrwdt), (k % 3 == 2) ? 32'd0 : 32'd1);
    end
    chk("p0_missed", 32'(o_missed_tasks), 32'd0);

    // All tasks at COLLECT cycle 2, then enable dropped in the first KICK cycle.
    i_kick_period = 10; i_holdoff = 3; i_task_alive = '0; i_enable = 1'b0;
    tick();
    i_enable = 1'b1;
    repeat (3) tick();
    tick();
    chk("ek_collect1", 32'(o_state), 32'd2);
    tick();
    i_task_alive = 4'b1111;
    tick();
    i_task_alive = '0;
    if (!EARLY) begin
      chk("ek_no_early_state", 32'(o_state), 32'd2);
      chk("ek_no_early_clr", 32'(o_clrwdt), 32'd0);
      repeat (7) tick();
      tick();
    end
    chk("ek_kick_state", 32'(o_state), 32'd3);
    chk("ek_kick_clr", 32'(o_clrwdt), 32'd1);
    i_enable = 1'b0;
    tick();
    chk("ek_dis_state", 32'(o_state), 32'd0);
    chk("ek_dis_clr", 32'(o_clrwdt), 32'd0);

    // Asynchronous reset clears state and counters without a clock edge.
    i_rst_n = 1'b0;
    #1;
    chk("arst_fail", 32'(o_fail_count), 32'd0);
    chk("arst_rstcnt", 32'(o_rst_count), 32'd0);
    chk("arst_state", 32'(o_state), 32'd0);
    model_reset();
    tick();
    i_rst_n = 1'b1;

    // Random stimulus against the model.
    hw_left = 0;
    i_kick_period = 5; i_holdoff = 2;
    for (int c = 0; c < 3000; c++) begin
      i_enable = ($urandom_range(0, 199) != 0);
      if (hw_left > 0) hw_left--;
      else if ($urandom_range(0, 149) == 0) hw_left = $urandom_range(1, 6);
      i_hardware_rst = (hw_left > 0);
      i_fail_safe = ($urandom_range(0, 5) == 0);
      for (int b = 0; b < NT; b++) i_task_alive[b] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) begin
        i_kick_period = $urandom_range(0, 8);
        i_holdoff = $urandom_range(0, 4);
      end
      model_tick();
      tick();
      chk("rnd_state", 32'(o_state), 32'(m_st));
      chk("rnd_clr", 32'(o_clrwdt), 32'(m_clr));
      chk("rnd_missed", 32'(o_missed_tasks), 32'(m_missed));
      chk("rnd_fail", 32'(o_fail_count), 32'(m_fail));
      chk("rnd_rstcnt", 32'(o_rst_count), 32'(m_rst));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
